// File: rtl/aes_pkg.sv
// Shared AES constants: S-box table, block geometry
// and the byte-index helper for [0:127] big-endian ordering.
package aes_pkg;

  localparam int AES_BLOCK_BITS = 128;
  localparam int AES_BYTE_BITS  = 8;
  localparam int AES_IDX_BITS   = $clog2(AES_BLOCK_BITS);

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Byte k occupies bits [8k:8k+7]; returns the low index 8k.
  function automatic logic [AES_IDX_BITS-1:0] byte_base(input int k);
    return AES_IDX_BITS'(k * AES_BYTE_BITS);
  endfunction

endpackage

// File: rtl/sub_bytes_iter_if.sv
// Valid/ready input and output streams of the
// iterative SubBytes stage.
interface sub_bytes_iter_if;
  import aes_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [0:AES_BLOCK_BITS-1] in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [0:AES_BLOCK_BITS-1] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box lookup.
// Shared by SubBytes and key expansion.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [AES_BYTE_BITS-1:0] byte_val,
  output logic [AES_BYTE_BITS-1:0] sub_val
);

  assign sub_val = SBOX[byte_val];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative SubBytes: BYTES_PER_CYCLE shared S-boxes
// walk the 16-byte state in place, chunk by chunk.
module sub_bytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  sub_bytes_iter_if.slave bus,
  output logic            busy
);

  localparam int B  = BYTES_PER_CYCLE;
  localparam int NB = AES_BLOCK_BITS / AES_BYTE_BITS;
  localparam int N  = NB / B;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  if (!(B == 1 || B == 2 || B == 4 ||
        B == 8 || B == 16)) begin : g_bad_b
    $error("BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]                state;
  logic [CW-1:0]             cnt;
  logic [0:AES_BLOCK_BITS-1] work;
  logic [0:AES_BLOCK_BITS-1] work_nxt;
  logic [AES_BYTE_BITS-1:0]  lane_in  [B];
  logic [AES_BYTE_BITS-1:0]  lane_out [B];
  logic                      is_idle;
  logic                      is_busy;
  logic                      is_done;
  logic                      last;

  assign is_idle = (state == S_IDLE);
  assign is_busy = (state == S_BUSY);
  assign is_done = (state == S_DONE);
  assign last    = (cnt == LAST);

  always_comb begin
    for (int i = 0; i < B; i++) begin
      lane_in[i] =
        work[byte_base(int'(cnt) * B + i) +: AES_BYTE_BITS];
    end
  end

  for (genvar g = 0; g < B; g++) begin : g_lane
    aes_sbox u_sbox (
      .byte_val (lane_in[g]),
      .sub_val  (lane_out[g])
    );
  end

  // Write the substituted lanes back over their source bytes.
  always_comb begin
    work_nxt = work;
    for (int i = 0; i < B; i++) begin
      work_nxt[byte_base(int'(cnt) * B + i) +: AES_BYTE_BITS] =
        lane_out[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      work  <= '0;
    end else begin
      unique case (1'b1)
        is_idle: begin
          if (bus.in_valid) begin
            work  <= bus.in_data;
            cnt   <= '0;
            state <= S_BUSY;
          end
        end
        is_busy: begin
          work <= work_nxt;
          cnt  <= last ? '0 : cnt + 1'b1;
          if (last) state <= S_DONE;
        end
        is_done: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = is_idle;
  assign bus.out_valid = is_done;
  assign bus.out_data  = work;
  assign busy          = is_busy;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Bench for sub_bytes_iter: B=1..16 instances, reference S-box
// derived from GF(2^8) inversion plus the affine map.
module tb_sub_bytes_iter;

  localparam int M = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         in_valid = 1'b0;
  logic [0:127] in_data = '0;
  logic         out_ready = 1'b0;
  logic [4:0]   en = 5'b00100;

  logic [4:0]   rdy_a;
  logic [4:0]   vld_a;
  logic [4:0]   busy_a;
  logic [0:127] dout_a [5];

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] sref [256];

  for (genvar g = 0; g < 5; g++) begin : g_dut
    sub_bytes_iter_if bus ();
    assign bus.in_valid  = in_valid & en[g];
    assign bus.in_data   = in_data;
    assign bus.out_ready = out_ready;
    assign rdy_a[g]      = bus.in_ready;
    assign vld_a[g]      = bus.out_valid;
    assign dout_a[g]     = bus.out_data;
    sub_bytes_iter #(.BYTES_PER_CYCLE(1 << g)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus),
      .busy  (busy_a[g])
    );
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic hi;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a = a << 1;
      if (hi) a = a ^ 8'h1b;
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  function automatic logic [0:127] model(input logic [0:127] d);
    logic [0:127] r;
    logic [6:0] p;
    for (int k = 0; k < 16; k++) begin
      p = 7'(8 * k);
      r[p +: 8] = sref[d[p +: 8]];
    end
    return r;
  endfunction

  function automatic logic [0:127] shift_rows(input logic [0:127] d);
    logic [0:127] r;
    logic [6:0] dst, src;
    for (int ro = 0; ro < 4; ro++)
      for (int c = 0; c < 4; c++) begin
        dst = 7'(8 * (ro + 4 * c));
        src = 7'(8 * (ro + 4 * ((c + ro) % 4)));
        r[dst +: 8] = d[src +: 8];
      end
    return r;
  endfunction

  function automatic logic [0:127] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out", name);
  endtask

  task automatic wait_ready();
    int i = 0;
    while (!rdy_a[M] && i < 100) begin
      @(negedge clk);
      i++;
    end
    if (!rdy_a[M]) timeout("wait_ready");
  endtask

  task automatic run_one(input logic [0:127] din, input logic [0:127] exp,
                         input int stall, input string name,
                         output logic [0:127] got);
    int lat;
    got = 'x;
    wait_ready();
    in_valid  = 1'b1;
    in_data   = din;
    out_ready = (stall == 0);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = rnd128();
    lat = 0;
    while (!vld_a[M] && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!vld_a[M]) begin
      timeout({name, "_valid"});
    end else begin
      chk({name, "_lat"}, lat, 4);
      chk({name, "_data"}, dout_a[M], exp);
      got = dout_a[M];
      if (stall > 0) begin
        repeat (stall) @(negedge clk);
        chk({name, "_held"}, {vld_a[M], dout_a[M]}, {1'b1, exp});
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
  endtask

  typedef struct {
    string        name;
    logic [0:127] din;
    logic [0:127] dout;
  } vec_t;

  vec_t vt [4];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] inv;
    logic [0:127] got, a, b, c1_in, c1_out;
    int acc [2];
    int n, seen;
    int lat [5];
    logic [0:127] sd [5];
    logic [0:127] q [$];

    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^
                rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end

    c1_in  = 128'h00102030405060708090a0b0c0d0e0f0;
    c1_out = 128'h63cab7040953d051cd60e0e7ba70e18c;
    vt[0] = '{"c1",   c1_in, c1_out};
    vt[1] = '{"zero", 128'h0, {16{8'h63}}};
    vt[2] = '{"ones", {16{8'hff}}, {16{8'h16}}};
    vt[3] = '{"b53",  {8'h53, 120'h0}, {8'hed, {15{8'h63}}}};

    @(negedge clk);
    chk("rst_in_ready", rdy_a[M], 1);
    chk("rst_out_valid", vld_a[M], 0);
    chk("rst_busy", busy_a[M], 0);
    chk("rst_out_data", dout_a[M], 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++)
      run_one(vt[i].din, vt[i].dout, 0, vt[i].name, got);

    run_one(c1_in, c1_out, 0, "c1_again", got);
    chk("c1_shift_rows", shift_rows(got),
        128'h6353e08c0960e104cd70b751bacad0e7);

    for (int i = 0; i < 12; i++) begin
      a = rnd128();
      run_one(a, model(a), $urandom_range(0, 3),
              $sformatf("rand%0d", i), got);
    end

    // Backpressure: held output, second request refused.
    a = rnd128();
    wait_ready();
    in_valid = 1'b1;
    in_data  = a;
    @(negedge clk);
    in_valid = 1'b0;
    n = 0;
    while (!vld_a[M] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!vld_a[M]) timeout("bp_valid");
    in_valid = 1'b1;
    in_data  = rnd128();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("bp_hold%0d", i),
          {vld_a[M], rdy_a[M], dout_a[M]}, {2'b10, model(a)});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release", {vld_a[M], rdy_a[M], busy_a[M]}, 3'b010);

    // Back-to-back with in_valid held high.
    a = rnd128();
    b = rnd128();
    in_valid  = 1'b1;
    in_data   = a;
    out_ready = 1'b1;
    n = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (in_valid && rdy_a[M] && n < 2) begin
        acc[n] = cyc;
        n++;
      end
      if (vld_a[M]) q.push_back(dout_a[M]);
      @(negedge clk);
      if (n == 1) in_data = b;
      if (n == 2) in_valid = 1'b0;
    end
    out_ready = 1'b0;
    chk("b2b_accepts", n, 2);
    if (n == 2) chk("b2b_gap", acc[1] - acc[0], 6);
    chk("b2b_outputs", q.size(), 2);
    if (q.size() >= 2) begin
      chk("b2b_first", q[0], model(a));
      chk("b2b_second", q[1], model(b));
    end

    // Reset after two chunks have been processed.
    wait_ready();
    in_valid  = 1'b1;
    in_data   = rnd128();
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_outs", {rdy_a[M], vld_a[M], busy_a[M]}, 3'b100);
    chk("mid_rst_data", dout_a[M], 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (vld_a[M]) seen++;
    end
    chk("mid_rst_no_valid", seen, 0);
    out_ready = 1'b0;
    run_one(c1_in, c1_out, 1, "post_rst", got);

    // Parameter sweep: one accept edge shared by all widths.
    en = 5'b11111;
    wait_ready();
    in_valid  = 1'b1;
    in_data   = c1_in;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int g = 0; g < 5; g++) lat[g] = -1;
    for (int cyc = 0; cyc < 24; cyc++) begin
      for (int g = 0; g < 5; g++)
        if (vld_a[g] && lat[g] < 0) begin
          lat[g] = cyc;
          sd[g]  = dout_a[g];
        end
      @(negedge clk);
    end
    for (int g = 0; g < 5; g++) begin
      chk($sformatf("sweep_lat_b%0d", 1 << g), lat[g], 16 >> g);
      chk($sformatf("sweep_data_b%0d", 1 << g), sd[g], c1_out);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sub_bytes_iter.md
# sub_bytes_iter

Iterative AES SubBytes stage that sits directly upstream of `shift_rows` in the round datapath. It accepts one 128-bit state over a valid/ready handshake and substitutes `BYTES_PER_CYCLE` bytes per clock through shared S-box instances. It then presents the substituted state on an output valid/ready handshake that feeds `shift_rows`. This trades latency for area: 4 S-boxes instead of 16 at the default setting.

## Interface
- `BYTES_PER_CYCLE`, default 4: number of S-box lookups per cycle. Legal values are 1, 2, 4, 8 and 16; any other value is an elaboration error.
- `clk`  in  1: the single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `in_valid`  in  1: `in_data` holds a state to substitute.
- `in_ready`  out  1: block can accept a state.
- `in_data`  in  [0:127]: input state. Byte k is bits [8k:8k+7], so byte 0 is the MSB byte, in FIPS-197 column-major order.
- `out_valid`  out  1: `out_data` holds a completed substituted state.
- `out_ready`  in  1: downstream (`shift_rows` register) accepts `out_data`.
- `out_data`  out  [0:127]: substituted state, same byte ordering as `in_data`.
- `busy`  out  1: a substitution is in progress.

## Operation
- FSM states are IDLE, BUSY and DONE. Let N = 16 / `BYTES_PER_CYCLE`.
- **IDLE**
  - `in_ready`=1.
  - When `in_valid`&&`in_ready` at a clock edge: capture `in_data` into the work register, clear the chunk counter, and go to BUSY.
- **BUSY**
  - `in_ready`=0 and `busy`=1.
  - On each edge, bytes [c·B .. c·B+B−1] of the work register (c = counter, B = `BYTES_PER_CYCLE`) are replaced by their S-box values in place, then c increments.
  - The chunk with c = N−1 completes the block: the FSM goes to DONE and the counter wraps to 0.
  - The counter is ⌈log2(N)⌉ bits wide, minimum 1; for N=1, BUSY lasts exactly one cycle.
- **DONE**
  - `out_valid`=1 and `out_data` = work register, held stable while `out_ready`=0.
  - `in_ready`=0, so no new input is accepted until the output handshake completes.
  - `out_valid`&&`out_ready` at an edge: go to IDLE.
- `out_data` equals the work register in every state. Its value outside DONE is don't-care to consumers, but it is deterministic.
- `in_data` is sampled only at the accept edge; changes afterwards have no effect.
- `in_valid` in BUSY or DONE is ignored. The upstream block must hold it until `in_ready`.
- Asserting `rst_n` low mid-operation aborts the block immediately. The partial state is discarded and not output.

## Timing
- Reset values:
  - state = IDLE, `in_ready`=1, `out_valid`=0, `busy`=0, counter=0.
  - Work register and `out_data` = 128'h0.
- Accept at edge t: `busy` rises after t, and `out_valid` rises after edge t+N.
- Latency, accept to `out_valid`: N cycles (4 at default).
- With `out_ready` tied high, DONE lasts 1 cycle and `in_ready` returns after edge t+N+1. Maximum throughput is one block per N+2 cycles.
- Backpressure: DONE persists indefinitely. `out_data` and `out_valid` must not change until the handshake completes.
- Handshake outputs are registered-state decodes, with no combinational path from `in_valid` or `out_ready` to `in_ready` or `out_valid`.
- The S-box path is combinational from the work register to its update, so there is one S-box delay per cycle.

## Structure
- Shared package `aes_pkg` holds:
  - the 256-entry S-box constant table;
  - `AES_BLOCK_BITS`=128 and `AES_BYTE_BITS`=8;
  - the byte-index helper for [0:127] ordering.
- Sub-module `aes_sbox`: 8-bit in, 8-bit out, combinational lookup from `aes_pkg`, instantiated `BYTES_PER_CYCLE` times via generate. It is reused by the later key-expansion and inverse blocks.
- `sub_bytes_iter` itself contains the FSM, chunk counter, work register and byte-lane mux/demux.

## Test plan
- Default B=4, FIPS-197 C.1 round 1: `in_data`=00102030405060708090a0b0c0d0e0f0 → `out_data`=63cab7040953d051cd60e0e7ba70e18c, `out_valid` exactly 4 cycles after the accept edge. Feeding this output to `shift_rows` gives 6353e08c0960e104cd70b751bacad0e7.
- Corner values: all-zero in → 636363…63 (16 bytes); all-ff in → 161616…16; byte 0=53, rest 00 → ed636363…63.
- Parameter sweep at B=1, 2, 8 and 16: the C.1 vector gives the same result, with latency 16, 8, 2 and 1 cycles respectively.
- Backpressure:
  - hold `out_ready`=0 for 10 cycles in DONE: `out_data` is stable, `in_ready`=0, and a second `in_valid` is not accepted;
  - release `out_ready`: one handshake, then IDLE with `in_ready`=1.
- Back-to-back: two blocks with `out_ready`=1 and `in_valid` held high are accepted N+2 cycles apart, with correct outputs in order.
- Reset mid-BUSY: pulse `rst_n` low after 2 chunks → outputs immediately return to reset values, no `out_valid` occurs, and a new block then completes correctly.
